// File: rtl/wb_mem_arbiter.sv
// Two-master (CPU, DMA) round-robin Wishbone arbiter in front of user-project memory.
// One transaction per grant, a dead DONE cycle after each, and a no-ack timeout that errors the master.
module wb_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic          c_cyc_i,
    input  logic          c_stb_i,
    input  logic          c_we_i,
    input  logic [3:0]    c_sel_i,
    input  logic [AW-1:0] c_adr_i,
    input  logic [DW-1:0] c_dat_i,
    output logic [DW-1:0] c_dat_o,
    output logic          c_ack_o,
    output logic          c_err_o,
    input  logic          d_cyc_i,
    input  logic          d_stb_i,
    input  logic          d_we_i,
    input  logic [3:0]    d_sel_i,
    input  logic [AW-1:0] d_adr_i,
    input  logic [DW-1:0] d_dat_i,
    output logic [DW-1:0] d_dat_o,
    output logic          d_ack_o,
    output logic          d_err_o,
    output logic          m_cyc_o,
    output logic          m_stb_o,
    output logic          m_we_o,
    output logic [3:0]    m_sel_o,
    output logic [AW-1:0] m_adr_o,
    output logic [DW-1:0] m_dat_o,
    input  logic [DW-1:0] m_dat_i,
    input  logic          m_ack_i
);

    typedef enum logic [1:0] {IDLE, GNT_C, GNT_D, DONE} state_t;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t        r_state;
    logic          r_lastGrantDma;
    logic [TW-1:0] r_timer;

    logic w_cReq;
    logic w_dReq;
    logic w_cGnt;
    logic w_dGnt;
    logic w_grantedCyc;
    logic w_timeout;

    assign w_cReq       = c_cyc_i & c_stb_i;
    assign w_dReq       = d_cyc_i & d_stb_i;
    assign w_cGnt       = (r_state == GNT_C);
    assign w_dGnt       = (r_state == GNT_D);
    assign w_grantedCyc = (w_cGnt & c_cyc_i) | (w_dGnt & d_cyc_i);
    assign w_timeout    = (r_timer == TIMER_LAST);

    // Ack beats timeout in the same cycle; an aborted (cyc low) master sees neither.
    assign c_ack_o = w_cGnt & c_cyc_i & m_ack_i;
    assign d_ack_o = w_dGnt & d_cyc_i & m_ack_i;
    assign c_err_o = w_cGnt & c_cyc_i & ~m_ack_i & w_timeout;
    assign d_err_o = w_dGnt & d_cyc_i & ~m_ack_i & w_timeout;
    assign c_dat_o = w_cGnt ? m_dat_i : '0;
    assign d_dat_o = w_dGnt ? m_dat_i : '0;

    always_comb begin
        m_cyc_o = 1'b0;
        m_stb_o = 1'b0;
        m_we_o  = 1'b0;
        m_sel_o = '0;
        m_adr_o = '0;
        m_dat_o = '0;
        if (w_cGnt) begin
            m_cyc_o = w_cReq;
            m_stb_o = w_cReq;
            m_we_o  = c_we_i;
            m_sel_o = c_sel_i;
            m_adr_o = c_adr_i;
            m_dat_o = c_dat_i;
        end else if (w_dGnt) begin
            m_cyc_o = w_dReq;
            m_stb_o = w_dReq;
            m_we_o  = d_we_i;
            m_sel_o = d_sel_i;
            m_adr_o = d_adr_i;
            m_dat_o = d_dat_i;
        end
    end

    // Reset leaves last grant at DMA so the CPU wins the first tie.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state        <= IDLE;
            r_lastGrantDma <= 1'b1;
            r_timer        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timer <= '0;
                    if (w_cReq && (!w_dReq || r_lastGrantDma)) begin
                        r_state        <= GNT_C;
                        r_lastGrantDma <= 1'b0;
                    end else if (w_dReq) begin
                        r_state        <= GNT_D;
                        r_lastGrantDma <= 1'b1;
                    end
                end
                GNT_C, GNT_D: begin
                    if (!w_grantedCyc) begin
                        r_state <= IDLE;
                    end else if (m_ack_i || w_timeout) begin
                        r_state <= DONE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter (TIMEOUT=4): reset, single read, tie-break, alternation,
// timeout, ack/timeout coincidence, abort, and asynchronous reset mid-cycle.
module tb_wb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_n_i;
    logic          c_cyc_i, c_stb_i, c_we_i;
    logic [3:0]    c_sel_i;
    logic [AW-1:0] c_adr_i;
    logic [DW-1:0] c_dat_i;
    logic [DW-1:0] c_dat_o;
    logic          c_ack_o, c_err_o;
    logic          d_cyc_i, d_stb_i, d_we_i;
    logic [3:0]    d_sel_i;
    logic [AW-1:0] d_adr_i;
    logic [DW-1:0] d_dat_i;
    logic [DW-1:0] d_dat_o;
    logic          d_ack_o, d_err_o;
    logic          m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]    m_sel_o;
    logic [AW-1:0] m_adr_o;
    logic [DW-1:0] m_dat_o;
    logic [DW-1:0] m_dat_i;
    logic          m_ack_i;

    int compared   = 0;
    int mismatched = 0;

    wb_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4), .TW(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .c_cyc_i(c_cyc_i), .c_stb_i(c_stb_i), .c_we_i(c_we_i), .c_sel_i(c_sel_i),
        .c_adr_i(c_adr_i), .c_dat_i(c_dat_i), .c_dat_o(c_dat_o), .c_ack_o(c_ack_o),
        .c_err_o(c_err_o),
        .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i),
        .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_dat_o(d_dat_o), .d_ack_o(d_ack_o),
        .d_err_o(d_err_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here, checks follow #1 later.
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic cReq, input logic dReq);
        c_cyc_i = cReq;
        c_stb_i = cReq;
        d_cyc_i = dReq;
        d_stb_i = dReq;
    endtask

    initial begin
        wb_rst_n_i = 1'b0;
        applyStimulus(1'b0, 1'b0);
        c_we_i = 1'b0; c_sel_i = 4'hF; c_adr_i = '0; c_dat_i = '0;
        d_we_i = 1'b0; d_sel_i = 4'hF; d_adr_i = '0; d_dat_i = '0;
        m_ack_i = 1'b1;
        m_dat_i = 32'h5A5A_5A5A;

        // Reset: nothing forwarded even with a stray ack on the bus
        #12;
        checkOutput("rst_m_cyc", m_cyc_o, 0);
        checkOutput("rst_c_ack", c_ack_o, 0);
        checkOutput("rst_d_ack", d_ack_o, 0);
        checkOutput("rst_c_dat", c_dat_o, 0);
        checkOutput("rst_d_dat", d_dat_o, 0);
        m_ack_i = 1'b0;
        wb_rst_n_i = 1'b1;

        // Single CPU read, memory acks on the third grant cycle
        tick();
        c_adr_i = 32'h3800_0100;
        applyStimulus(1'b1, 1'b0);
        #1 checkOutput("t1_idle_m_cyc", m_cyc_o, 0);
        tick();
        #1 checkOutput("t1_g1_m_cyc", m_cyc_o, 1);
        checkOutput("t1_g1_m_adr", m_adr_o, 64'h3800_0100);
        checkOutput("t1_g1_c_ack", c_ack_o, 0);
        tick();
        #1 checkOutput("t1_g2_c_ack", c_ack_o, 0);
        tick();
        m_ack_i = 1'b1; m_dat_i = 32'hDEAD_BEEF;
        #1 checkOutput("t1_g3_c_ack", c_ack_o, 1);
        checkOutput("t1_g3_c_dat", c_dat_o, 64'hDEAD_BEEF);
        checkOutput("t1_g3_d_ack", d_ack_o, 0);
        checkOutput("t1_g3_c_err", c_err_o, 0);
        tick();
        m_ack_i = 1'b0;
        applyStimulus(1'b0, 1'b0);
        #1 checkOutput("t1_done_m_cyc", m_cyc_o, 0);
        checkOutput("t1_done_c_ack", c_ack_o, 0);
        tick();

        // Fresh reset, then simultaneous CPU write and DMA read
        wb_rst_n_i = 1'b0;
        #2 wb_rst_n_i = 1'b1;
        tick();
        c_we_i = 1'b1; c_adr_i = 32'h3800_0000; c_dat_i = 32'h11; c_sel_i = 4'hF;
        d_we_i = 1'b0; d_adr_i = 32'h3800_0104;
        applyStimulus(1'b1, 1'b1);
        tick();
        m_ack_i = 1'b1; m_dat_i = 32'hAAAA_5555;
        #1 checkOutput("t2_c_m_cyc", m_cyc_o, 1);
        checkOutput("t2_c_m_we", m_we_o, 1);
        checkOutput("t2_c_m_sel", m_sel_o, 4'hF);
        checkOutput("t2_c_m_adr", m_adr_o, 64'h3800_0000);
        checkOutput("t2_c_m_dat", m_dat_o, 64'h11);
        checkOutput("t2_c_c_ack", c_ack_o, 1);
        checkOutput("t2_c_d_ack", d_ack_o, 0);
        checkOutput("t2_c_d_dat", d_dat_o, 0);
        tick();
        m_ack_i = 1'b0;
        applyStimulus(1'b0, 1'b1);
        #1 checkOutput("t2_done_m_cyc", m_cyc_o, 0);
        tick();
        #1 checkOutput("t2_idle_m_cyc", m_cyc_o, 0);
        tick();
        m_ack_i = 1'b1; m_dat_i = 32'h1234_5678;
        #1 checkOutput("t2_d_m_adr", m_adr_o, 64'h3800_0104);
        checkOutput("t2_d_m_we", m_we_o, 0);
        checkOutput("t2_d_d_ack", d_ack_o, 1);
        checkOutput("t2_d_d_dat", d_dat_o, 64'h1234_5678);
        checkOutput("t2_d_c_ack", c_ack_o, 0);
        checkOutput("t2_d_c_dat", c_dat_o, 0);
        tick();
        m_ack_i = 1'b0;
        applyStimulus(1'b0, 1'b0);
        tick();

        // Both masters hold requests; memory ack held high so each grant lasts one cycle
        c_we_i = 1'b0; c_adr_i = 32'h0000_0100;
        d_adr_i = 32'h0000_0200;
        applyStimulus(1'b1, 1'b1);
        m_ack_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic expC;
            expC = (k % 2 == 0);
            #1 checkOutput($sformatf("t3_idle%0d_m_cyc", k), m_cyc_o, 0);
            checkOutput($sformatf("t3_idle%0d_c_ack", k), c_ack_o, 0);
            tick();
            #1 checkOutput($sformatf("t3_gnt%0d_m_adr", k), m_adr_o, expC ? 64'h100 : 64'h200);
            checkOutput($sformatf("t3_gnt%0d_c_ack", k), c_ack_o, expC);
            checkOutput($sformatf("t3_gnt%0d_d_ack", k), d_ack_o, !expC);
            tick();
            #1 checkOutput($sformatf("t3_done%0d_m_cyc", k), m_cyc_o, 0);
            checkOutput($sformatf("t3_done%0d_d_ack", k), d_ack_o, 0);
            tick();
        end
        applyStimulus(1'b0, 1'b0);
        m_ack_i = 1'b0;
        tick();

        // DMA request with no memory ack: error on the 4th grant cycle
        d_adr_i = 32'h0000_0300;
        applyStimulus(1'b0, 1'b1);
        tick();
        #1 checkOutput("t4_g1_d_err", d_err_o, 0);
        tick();
        tick();
        #1 checkOutput("t4_g3_d_err", d_err_o, 0);
        checkOutput("t4_g3_m_cyc", m_cyc_o, 1);
        tick();
        #1 checkOutput("t4_g4_d_err", d_err_o, 1);
        checkOutput("t4_g4_d_ack", d_ack_o, 0);
        checkOutput("t4_g4_c_err", c_err_o, 0);
        tick();
        applyStimulus(1'b0, 1'b0);
        #1 checkOutput("t4_done_m_cyc", m_cyc_o, 0);
        checkOutput("t4_done_d_err", d_err_o, 0);
        tick();
        #1 checkOutput("t4_idle_m_cyc", m_cyc_o, 0);

        // Ack arrives exactly on the timeout cycle: ack wins
        c_adr_i = 32'h0000_0500;
        applyStimulus(1'b1, 1'b0);
        tick();
        tick();
        tick();
        tick();
        m_ack_i = 1'b1; m_dat_i = 32'hCAFE_F00D;
        #1 checkOutput("t5_c_ack", c_ack_o, 1);
        checkOutput("t5_c_err", c_err_o, 0);
        checkOutput("t5_c_dat", c_dat_o, 64'hCAFE_F00D);
        tick();
        m_ack_i = 1'b0;
        applyStimulus(1'b0, 1'b0);
        #1 checkOutput("t5_done_c_ack", c_ack_o, 0);
        tick();

        // DMA aborts before ack; a late memory ack must not reach it
        d_adr_i = 32'h0000_0400;
        applyStimulus(1'b0, 1'b1);
        tick();
        #1 checkOutput("t6_g1_m_cyc", m_cyc_o, 1);
        tick();
        applyStimulus(1'b0, 1'b0);
        #1 checkOutput("t6_abort_m_cyc", m_cyc_o, 0);
        checkOutput("t6_abort_d_err", d_err_o, 0);
        tick();
        m_ack_i = 1'b1;
        #1 checkOutput("t6_late_d_ack", d_ack_o, 0);
        checkOutput("t6_late_m_cyc", m_cyc_o, 0);
        tick();
        m_ack_i = 1'b0;

        // CPU cycle interrupted by reset; afterwards a tie must go to the CPU again
        c_adr_i = 32'h0000_0600;
        d_adr_i = 32'h0000_0700;
        applyStimulus(1'b1, 1'b0);
        tick();
        #1 checkOutput("t7_g1_m_cyc", m_cyc_o, 1);
        #1 wb_rst_n_i = 1'b0;
        m_ack_i = 1'b1;
        #1 checkOutput("t7_rst_m_cyc", m_cyc_o, 0);
        checkOutput("t7_rst_m_stb", m_stb_o, 0);
        checkOutput("t7_rst_c_ack", c_ack_o, 0);
        tick();
        wb_rst_n_i = 1'b1;
        m_ack_i = 1'b0;
        applyStimulus(1'b1, 1'b1);
        tick();
        #1 checkOutput("t7_tie_m_adr", m_adr_o, 64'h600);
        checkOutput("t7_tie_m_cyc", m_cyc_o, 1);
        m_ack_i = 1'b1;
        #1 checkOutput("t7_tie_c_ack", c_ack_o, 1);
        checkOutput("t7_tie_d_ack", d_ack_o, 0);
        tick();
        m_ack_i = 1'b0;
        applyStimulus(1'b0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
